seq_restoring_divider: RTL

- Multi-cycle unsigned integer divider for the ALU datapath. It is the inverse operation to the adder chain: repeated trial subtraction with restore.
- Accepts dividend and divisor on a start pulse and iterates one quotient bit per clock.
- Returns quotient, remainder and a divide-by-zero flag with a one-cycle done pulse.
- Sits beside the combinational ALU ops; the ALU control FSM stalls on busy.

---
 rtl/div_pkg.sv | 19 +
 rtl/seq_restoring_divider_trial_subtractor.sv | 29 ++
 rtl/seq_restoring_divider.sv | 163 ++++++++++++++++
 3 files changed

// File: rtl/div_pkg.sv
// Shared types and constants for the sequential restoring divider.
package div_pkg;

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        DONE
    } state_t;

    localparam int MAX_W = 32;

    // Quotient reported on divide-by-zero (sliced to WIDTH by the user)
    localparam logic [MAX_W-1:0] DBZ_Q = '1;

    function automatic int cnt_w(input int w);
        return $clog2(w);
    endfunction

endpackage

// File: rtl/seq_restoring_divider_trial_subtractor.sv
// WIDTH+1-bit trial subtract a - b as a ripple chain of full adders
// (b inverted, carry-in 1); borrow is the sign bit of the result.
module trial_subtractor #(
    parameter int WIDTH = 4
) (
    input  logic [WIDTH:0]   a_i,
    input  logic [WIDTH:0]   b_i,
    output logic [WIDTH-1:0] diff_o,
    output logic             borrow_o
);

    logic [WIDTH:0] c;
    logic [WIDTH:0] s;
    logic [WIDTH:0] nb;

    assign nb   = ~b_i;
    assign c[0] = 1'b1;

    for (genvar i = 0; i <= WIDTH; i++) begin : g_fa
        assign s[i] = a_i[i] ^ nb[i] ^ c[i];
        if (i < WIDTH) begin : g_c
            assign c[i+1] = (a_i[i] & nb[i]) | (c[i] & (a_i[i] ^ nb[i]));
        end
    end

    assign diff_o   = s[WIDTH-1:0];
    assign borrow_o = s[WIDTH];

endmodule

// File: rtl/seq_restoring_divider.sv
// Multi-cycle restoring divider, one quotient bit per clock.
// Define DIVIDER_SIGNED_EN for two's-complement operands.
module seq_restoring_divider
    import div_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic [WIDTH-1:0] Q,
    output logic [WIDTH-1:0] R,
    output logic             busy,
    output logic             done,
    output logic             dbz
);

    localparam int CW = cnt_w(WIDTH);

    state_t           state_q, state_d;
    logic [WIDTH-1:0] dvd_q, dvd_d;
    logic [WIDTH-1:0] dvs_q, dvs_d;
    logic [WIDTH-1:0] rem_q, rem_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] q_q, q_d;
    logic [WIDTH-1:0] r_q, r_d;
    logic             dbz_q, dbz_d;

    logic [WIDTH-1:0] rem_sh;
    logic [WIDTH-1:0] diff;
    logic             borrow;
    logic             qbit;
    logic [WIDTH-1:0] rem_nx;
    logic [WIDTH-1:0] dvd_nx;
    logic [WIDTH-1:0] mag_a;
    logic [WIDTH-1:0] mag_b;
    logic [WIDTH-1:0] q_fin;
    logic [WIDTH-1:0] r_fin;

`ifdef DIVIDER_SIGNED_EN
    logic sa_q, sa_d;
    logic sb_q, sb_d;

    assign mag_a = A[WIDTH-1] ? (~A + 1'b1) : A;
    assign mag_b = B[WIDTH-1] ? (~B + 1'b1) : B;
    // Truncation toward zero: remainder follows the dividend's sign
    assign q_fin = (sa_q ^ sb_q) ? (~dvd_nx + 1'b1) : dvd_nx;
    assign r_fin = sa_q ? (~rem_nx + 1'b1) : rem_nx;
`else
    assign mag_a = A;
    assign mag_b = B;
    assign q_fin = dvd_nx;
    assign r_fin = rem_nx;
`endif

    assign rem_sh = {rem_q[WIDTH-2:0], dvd_q[WIDTH-1]};

    trial_subtractor #(
        .WIDTH(WIDTH)
    ) u_sub (
        .a_i     ({1'b0, rem_sh}),
        .b_i     ({1'b0, dvs_q}),
        .diff_o  (diff),
        .borrow_o(borrow)
    );

    assign qbit   = ~borrow;
    assign rem_nx = qbit ? diff : rem_sh;
    assign dvd_nx = {dvd_q[WIDTH-2:0], qbit};

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            dvd_q   <= '0;
            dvs_q   <= '0;
            rem_q   <= '0;
            cnt_q   <= '0;
            q_q     <= '0;
            r_q     <= '0;
            dbz_q   <= 1'b0;
`ifdef DIVIDER_SIGNED_EN
            sa_q    <= 1'b0;
            sb_q    <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            dvd_q   <= dvd_d;
            dvs_q   <= dvs_d;
            rem_q   <= rem_d;
            cnt_q   <= cnt_d;
            q_q     <= q_d;
            r_q     <= r_d;
            dbz_q   <= dbz_d;
`ifdef DIVIDER_SIGNED_EN
            sa_q    <= sa_d;
            sb_q    <= sb_d;
`endif
        end
    end

    always_comb begin
        state_d = state_q;
        dvd_d   = dvd_q;
        dvs_d   = dvs_q;
        rem_d   = rem_q;
        cnt_d   = cnt_q;
        q_d     = q_q;
        r_d     = r_q;
        dbz_d   = dbz_q;
`ifdef DIVIDER_SIGNED_EN
        sa_d    = sa_q;
        sb_d    = sb_q;
`endif
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    dvd_d = mag_a;
                    dvs_d = mag_b;
                    rem_d = '0;
                    cnt_d = '0;
                    dbz_d = 1'b0;
`ifdef DIVIDER_SIGNED_EN
                    sa_d  = A[WIDTH-1];
                    sb_d  = B[WIDTH-1];
`endif
                    if (B == '0) begin
                        state_d = DONE;
                        q_d     = DBZ_Q[WIDTH-1:0];
                        r_d     = A;
                        dbz_d   = 1'b1;
                    end else begin
                        state_d = CALC;
                    end
                end
            end
            CALC: begin
                dvd_d = dvd_nx;
                rem_d = rem_nx;
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CW'(WIDTH - 1)) begin
                    state_d = DONE;
                    q_d     = q_fin;
                    r_d     = r_fin;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign Q    = q_q;
    assign R    = r_q;
    assign dbz  = dbz_q;
    assign busy = (state_q == CALC);
    assign done = (state_q == DONE);

endmodule
